// File: rtl/conv_pool_if.sv
// Pixel-in / result-out valid-ready streams of the conv/pool engine.
// The engine takes the slave side; the feeder/sink takes the master side.
interface conv_pool_if #(parameter int DATA_W = 16);
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave  (input  pix_valid, pix_data, out_ready,
                  output pix_ready, out_valid, out_data, out_last);
  modport master (output pix_valid, pix_data, out_ready,
                  input  pix_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/conv_pool_engine.sv
// Streaming KxK valid convolution / 2x2 stride-2 average pool over one square map per frame.
// K-1 line buffers feed a KxK window; a result is registered on the edge accepting its last pixel.
module conv_pool_engine #(
  parameter  int DATA_W  = 16,
  parameter  int IMG_MAX = 32,
  parameter  int K       = 5,
  parameter  int FRAC    = 11,
  localparam int SW      = $clog2(IMG_MAX+1),
  localparam int ACC_W   = 2*DATA_W + $clog2(K*K),
  localparam int CW      = $clog2(K*K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [SW-1:0]     img_size,
  input  logic              coef_we,
  input  logic [CW-1:0]     coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  conv_pool_if.slave        io,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  localparam int AW = $clog2(IMG_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic                               done_d, mode_q, ov, ol, accept, emit, last_pix, legal;
  logic [SW-1:0]                      n_q, r, c;
  logic [AW-1:0]                      cx;
  logic [DATA_W-1:0]                  od, conv_res, pool_res;
  logic [K*K-1:0][DATA_W-1:0]         coef;
  logic [K-1:0][K-1:0][DATA_W-1:0]    win, nwin;
  logic signed [ACC_W-1:0]            acc, sh;
  logic [ACC_W-DATA_W:0]              top;
  logic signed [DATA_W+1:0]           psum;

  assign cx           = c[AW-1:0];
  assign busy         = (state_q != IDLE);
  assign io.pix_ready = (state_q == RUN) && (!ov || io.out_ready);
  assign io.out_valid = ov;
  assign io.out_data  = od;
  assign io.out_last  = ol;
  assign accept       = io.pix_valid && io.pix_ready;
  assign last_pix     = (r == n_q - SW'(1)) && (c == n_q - SW'(1));
  assign emit         = mode_q ? (r[0] && c[0]) : (r >= SW'(K-1) && c >= SW'(K-1));
  assign legal        = mode ? (!img_size[0] && img_size >= SW'(2) && img_size <= SW'(IMG_MAX))
                             : (img_size >= SW'(K) && img_size <= SW'(IMG_MAX));

  // Line buffer j holds row r-1-j; each accepted pixel pushes its column one row deeper.
  for (genvar j = 0; j < K-1; j++) begin : g_lb
    logic [DATA_W-1:0] mem [IMG_MAX];
    logic [DATA_W-1:0] tap;
    assign tap = mem[cx];
    if (j == 0) begin : g_head
      always_ff @(posedge clk) if (accept) mem[cx] <= io.pix_data;
    end else begin : g_body
      always_ff @(posedge clk) if (accept) mem[cx] <= g_lb[j-1].tap;
    end
  end

  // nwin is the window including the pixel being accepted; row 0 is the oldest row.
  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_col
      if (j < K-1) begin : g_sh
        assign nwin[i][j] = win[i][j+1];
      end else if (i < K-1) begin : g_lbtap
        assign nwin[i][j] = g_lb[K-2-i].tap;
      end else begin : g_pix
        assign nwin[i][j] = io.pix_data;
      end
    end
  end

  always_ff @(posedge clk) if (accept) win <= nwin;

  for (genvar t = 0; t < K*K; t++) begin : g_mac
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    sum;
    assign prod = (2*DATA_W)'($signed(coef[t])) * (2*DATA_W)'($signed(nwin[t/K][t%K]));
    if (t == 0) begin : g_first
      assign sum = ACC_W'(prod);
    end else begin : g_next
      assign sum = g_mac[t-1].sum + ACC_W'(prod);
    end
  end

  assign acc      = g_mac[K*K-1].sum;
  assign sh       = acc >>> FRAC;
  assign top      = sh[ACC_W-1:DATA_W-1];
  assign conv_res = (&top || ~|top) ? sh[DATA_W-1:0]
                                    : {sh[ACC_W-1], {(DATA_W-1){~sh[ACC_W-1]}}};

  // Bottom-right 2x2 of the window is the pool quad when r and c are odd.
  assign psum     = (DATA_W+2)'($signed(nwin[K-2][K-2])) + (DATA_W+2)'($signed(nwin[K-2][K-1]))
                  + (DATA_W+2)'($signed(nwin[K-1][K-2])) + (DATA_W+2)'($signed(nwin[K-1][K-1]));
  assign pool_res = DATA_W'(psum >>> 2);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (start) begin
               if (legal) state_d = RUN;
               else       done_d  = 1'b1;
             end
      RUN:   if (accept && last_pix) state_d = DRAIN;
      // Hold DRAIN through the done cycle so a start coinciding with done is ignored.
      DRAIN: if (done)                      state_d = IDLE;
             else if (ov && io.out_ready)   done_d  = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done    <= 1'b0;
      mode_q  <= 1'b0;
      n_q     <= '0;
      r       <= '0;
      c       <= '0;
      cfg_err <= 1'b0;
      coef    <= '0;
      ov      <= 1'b0;
      od      <= '0;
      ol      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (state_q == IDLE && start) begin
        mode_q  <= mode;
        n_q     <= img_size;
        r       <= '0;
        c       <= '0;
        cfg_err <= !legal;
      end
      if (state_q == IDLE && coef_we && coef_addr < CW'(K*K)) coef[coef_addr] <= coef_data;
      if (accept) begin
        if (c == n_q - SW'(1)) begin
          c <= '0;
          r <= r + SW'(1);
        end else begin
          c <= c + SW'(1);
        end
      end
      if (accept && emit) begin
        ov <= 1'b1;
        od <= mode_q ? pool_res : conv_res;
        ol <= last_pix;
      end else if (io.out_ready) begin
        ov <= 1'b0;
        ol <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_pool_engine.sv
// Scoreboard bench for conv_pool_engine: frame-level reference model fills a queue,
// a negedge monitor pops and compares every output handshake.
module tb_conv_pool_engine;
  localparam int DATA_W = 16, IMG_MAX = 32, K = 5, FRAC = 11;
  localparam int SW = $clog2(IMG_MAX+1), CW = $clog2(K*K);

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, coef_we = 1'b0;
  logic [SW-1:0]     img_size = '0;
  logic [CW-1:0]     coef_addr = '0;
  logic [DATA_W-1:0] coef_data = '0;
  logic              busy, done, cfg_err;

  conv_pool_if #(.DATA_W(DATA_W)) io ();

  conv_pool_engine #(.DATA_W(DATA_W), .IMG_MAX(IMG_MAX), .K(K), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .img_size(img_size),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .io(io), .busy(busy), .done(done), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  typedef struct packed { logic [DATA_W-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;
  int tests = 0, fails = 0, cyc = 0, hs_cyc = 0, rdy_mode = 0;
  int img [IMG_MAX*IMG_MAX];
  int cf  [K*K];
  logic stalled = 1'b0, held_l;
  logic [DATA_W-1:0] held_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic summary_and_fatal(input string name);
    tests++; fails++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench aborted");
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Sink readiness: 0 always ready, 1 toggling, 2 random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       io.out_ready = 1'b1;
      1:       io.out_ready = ~io.out_ready;
      default: io.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) stalled = 1'b0;
    else begin
      if (stalled) begin
        chk("hold_valid", io.out_valid, 1);
        chk("hold_data", io.out_data, held_d);
        chk("hold_last", io.out_last, held_l);
      end
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got 0x%0h expected no output", io.out_data);
        end else begin
          e_mon = exp_q.pop_front();
          chk("out_data", io.out_data, e_mon.d);
          chk("out_last", io.out_last, e_mon.l);
          if (e_mon.l) hs_cyc = cyc;
        end
      end
      if (io.out_valid && !io.out_ready) chk("pix_ready_stall", io.pix_ready, 0);
      stalled = io.out_valid && !io.out_ready;
      held_d  = io.out_data;
      held_l  = io.out_last;
    end
  end

  // Reference: plain 2-D arithmetic over the whole frame, outputs in raster order.
  function automatic void push_expected(input bit m, input int n);
    exp_t e;
    longint s;
    if (!m) begin
      for (int orow = 0; orow <= n-K; orow++)
        for (int ocol = 0; ocol <= n-K; ocol++) begin
          s = 0;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              s += longint'(cf[i*K+j]) * longint'(img[(orow+i)*n + ocol+j]);
          s = s >>> FRAC;
          if (s > 32767)  s = 32767;
          if (s < -32768) s = -32768;
          e.d = s[DATA_W-1:0];
          e.l = (orow == n-K) && (ocol == n-K);
          exp_q.push_back(e);
        end
    end else begin
      for (int orow = 0; orow < n/2; orow++)
        for (int ocol = 0; ocol < n/2; ocol++) begin
          s = longint'(img[2*orow*n + 2*ocol]) + longint'(img[2*orow*n + 2*ocol+1])
            + longint'(img[(2*orow+1)*n + 2*ocol]) + longint'(img[(2*orow+1)*n + 2*ocol+1]);
          s = s >>> 2;
          e.d = s[DATA_W-1:0];
          e.l = (orow == n/2-1) && (ocol == n/2-1);
          exp_q.push_back(e);
        end
    end
  endfunction

  task automatic write_coef(input int addr, input int val);
    coef_we = 1'b1; coef_addr = CW'(addr); coef_data = DATA_W'(val);
    tick();
    coef_we = 1'b0;
    cf[addr] = val;
  endtask

  task automatic do_start(input bit m, input int n);
    start = 1'b1; mode = m; img_size = SW'(n);
    tick();
    start = 1'b0;
  endtask

  // First pixel also carries a coefficient write, which must be dropped while busy.
  task automatic send_pixels(input int cnt_px, input int gap_pct);
    bit took;
    int w;
    for (int k = 0; k < cnt_px; k++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        io.pix_valid = 1'b0;
        tick();
      end
      io.pix_valid = 1'b1;
      io.pix_data  = DATA_W'(img[k]);
      if (k == 0) begin
        coef_we = 1'b1; coef_addr = CW'($urandom_range(0, K*K-1)); coef_data = DATA_W'($urandom);
      end
      w = 0;
      do begin
        @(negedge clk); took = io.pix_ready;
        tick();
        coef_we = 1'b0;
        w++;
        if (w > 5000) summary_and_fatal("pix_ready_wait");
      end while (!took);
    end
    io.pix_valid = 1'b0;
  endtask

  task automatic wait_done(input bit legal, input bit poke);
    int w = 0;
    while (!done) begin
      tick();
      w++;
      if (w > 5000) summary_and_fatal("done_wait");
    end
    if (legal) chk("done_latency", cyc, hs_cyc + 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("out_valid_at_done", io.out_valid, 0);
    if (poke) begin start = 1'b1; mode = 1'b1; img_size = SW'(2); end
    tick();
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic run_frame(input bit m, input int n, input int gap, input int rmode, input bit poke);
    rdy_mode = rmode;
    push_expected(m, n);
    do_start(m, n);
    chk("busy_on_start", busy, 1);
    chk("cfg_err_cleared", cfg_err, 0);
    send_pixels(n*n, gap);
    wait_done(1'b1, poke);
  endtask

  task automatic illegal(input bit m, input int n);
    do_start(m, n);
    chk("ill_cfg_err", cfg_err, 1);
    chk("ill_done", done, 1);
    chk("ill_busy", busy, 0);
    tick();
    chk("ill_done_pulse", done, 0);
    chk("ill_cfg_err_sticky", cfg_err, 1);
    chk("ill_no_output", io.out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    summary_and_fatal("global_watchdog");
  end

  initial begin
    bit m;
    int n;
    io.pix_valid = 1'b0; io.pix_data = '0; io.out_ready = 1'b1;
    for (int t = 0; t < K*K; t++) cf[t] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0); chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_last", io.out_last, 0); chk("rst_out_data", io.out_data, 0);
    chk("rst_pix_ready", io.pix_ready, 0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 16; k++) img[k] = k;
    run_frame(1'b1, 4, 0, 0, 1'b0);

    write_coef(12, 'h0800);
    for (int k = 0; k < 25; k++) img[k] = k;
    run_frame(1'b0, 5, 0, 0, 1'b1);

    for (int t = 0; t < K*K; t++) write_coef(t, 'h0800);
    for (int k = 0; k < 1024; k++) img[k] = 32767;
    run_frame(1'b0, 32, 0, 0, 1'b0);
    for (int k = 0; k < 1024; k++) img[k] = -32768;
    run_frame(1'b0, 32, 0, 0, 1'b0);

    for (int k = 0; k < 16; k++) img[k] = k;
    run_frame(1'b1, 4, 0, 1, 1'b0);

    illegal(1'b0, 3);
    illegal(1'b1, 5);

    for (int f = 0; f < 8; f++) begin
      m = 1'($urandom_range(0, 1));
      n = m ? 2*int'($urandom_range(1, 6)) : int'($urandom_range(K, 12));
      for (int t = 0; t < K*K; t++)
        write_coef(t, (f % 3 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                   : int'($urandom_range(0, 4095)) - 2048);
      for (int k = 0; k < n*n; k++) img[k] = int'($urandom_range(0, 65535)) - 32768;
      run_frame(m, n, 30, 2, 1'b0);
    end
    for (int k = 0; k < 1024; k++) img[k] = int'($urandom_range(0, 65535)) - 32768;
    run_frame(1'b1, 32, 10, 2, 1'b0);

    rdy_mode = 0;
    for (int k = 0; k < 64; k++) img[k] = k;
    do_start(1'b0, 8);
    send_pixels(10, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);  chk("midrst_out_valid", io.out_valid, 0);
    chk("midrst_done", done, 0);  chk("midrst_pix_ready", io.pix_ready, 0);
    exp_q.delete();
    for (int t = 0; t < K*K; t++) cf[t] = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_done", done, 0);
    img[0] = -1; img[1] = -2; img[2] = -3; img[3] = -4;
    run_frame(1'b1, 2, 0, 0, 1'b0);
    for (int k = 0; k < 25; k++) img[k] = int'($urandom_range(0, 65535)) - 32768;
    run_frame(1'b0, 5, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
